// File: rtl/spi_sram_arbiter.sv
// Round-robin arbiter that shares one SPI SRAM master transaction port between
// the CPU cache (requester 0) and an auxiliary port (requester 1).
module spi_sram_arbiter #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            r_req,
    input  logic [2*ADDR_W-1:0]   r_addr,
    input  logic [1:0]            r_wr,
    input  logic [2*LEN_W-1:0]    r_len,
    input  logic [15:0]           r_wdata,
    output logic [1:0]            r_ack,
    output logic [1:0]            r_wnext,
    output logic [7:0]            r_rdata,
    output logic [1:0]            r_rvalid,
    output logic [1:0]            r_done,
    output logic                  m_start,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_wr,
    output logic [LEN_W-1:0]      m_len,
    input  logic                  m_busy,
    output logic [7:0]            m_wdata,
    input  logic                  m_wnext,
    input  logic [7:0]            m_rdata,
    input  logic                  m_rvalid,
    input  logic                  m_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                prio_q, prio_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                winner;

    // The prioritized requester wins only if it is actually requesting.
    assign winner = r_req[prio_q] ? prio_q : ~prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        prio_d   = prio_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        len_d    = len_q;
        r_ack    = 2'b00;
        r_wnext  = 2'b00;
        r_rvalid = 2'b00;
        r_done   = 2'b00;
        m_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|r_req) begin
                    grant_d = winner;
                    addr_d  = winner ? r_addr[2*ADDR_W-1:ADDR_W] : r_addr[ADDR_W-1:0];
                    wr_d    = r_wr[winner];
                    len_d   = winner ? r_len[2*LEN_W-1:LEN_W] : r_len[LEN_W-1:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A zero-length burst completes without ever touching the master.
                if (len_q == '0) begin
                    r_ack[grant_q]  = 1'b1;
                    r_done[grant_q] = 1'b1;
                    prio_d          = ~grant_q;
                    state_d         = IDLE;
                end else if (!m_busy) begin
                    m_start        = 1'b1;
                    r_ack[grant_q] = 1'b1;
                    state_d        = ACTIVE;
                end
            end
            ACTIVE: begin
                r_wnext[grant_q]  = m_wnext;
                r_rvalid[grant_q] = m_rvalid;
                r_done[grant_q]   = m_done;
                if (m_done) begin
                    prio_d  = ~grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_addr  = addr_q;
    assign m_wr    = wr_q;
    assign m_len   = len_q;
    assign m_wdata = grant_q ? r_wdata[15:8] : r_wdata[7:0];
    assign r_rdata = m_rdata;

endmodule
